cluster_sched: RTL and testbench
================================

# cluster_sched

Tile scheduler that time-multiplexes one 48-output matmul cluster over `N_TILES` output tiles of a fully-connected layer.
- Captures one image (`INPUT_SIZE` packed 12-bit pixel beats) into a local buffer.
- For each tile, latches one bias beat, replays the buffered image in lock-step with the tile's weight stream, then forwards the tile's `OUT_PER_TILE` activations downstream tagged with the tile index.
- Sits between the DMA-side AXI-stream sources and the cluster's x/w/b/a ports.

## Interface
- `INPUT_SIZE`, 784, pixel beats per image (3 packed 4-bit pixels per beat).
- `N_TILES`, 4, tiles per image.
- `OUT_PER_TILE`, 48, activation beats expected from the cluster per tile.
- `CLK` in 1: clock.
- `RST` in 1: synchronous, active-low reset.
- `start` in 1: begin one image; sampled only in IDLE.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after the last tile drains.
- `s_x_tdata`/`s_x_tvalid`/`s_x_tready` in/in/out 12/1/1: image pixel stream.
- `s_w_tdata`/`s_w_tvalid`/`s_w_tready` in/in/out 64/1/1: weight stream, `INPUT_SIZE` beats per tile.
- `s_b_tdata`/`s_b_tvalid`/`s_b_tready` in/in/out 64/1/1: bias stream, 1 beat per tile.
- `m_x_tdata`/`m_x_tvalid`/`m_x_tready` out/out/in 12/1/1: pixels to cluster.
- `m_w_tdata`/`m_w_tvalid`/`m_w_tready` out/out/in 64/1/1: weights to cluster.
- `m_b_tdata`/`m_b_tvalid` out/out 64/1: held bias to cluster; the cluster's `b_tready` is not used.
- `c_a_tdata`/`c_a_tvalid`/`c_a_tready` in/in/out 64/1/1: activations from cluster.
- `m_a_tdata`/`m_a_tvalid`/`m_a_tready`/`m_a_tlast`/`m_a_tuser` out/out/in/out/out 64/1/1/1/max(1,clog2(N_TILES)): activations downstream; `tuser` carries the tile index.
- `tile_idx` out max(1,clog2(N_TILES)): current tile.

## Operation
States: IDLE, LOAD_X, BIAS, RUN, DRAIN, DONE.
- **IDLE**
  - `start`=1 -> LOAD_X; clear `wr_ptr`, `rd_ptr`, `tile_idx`, `beat_cnt`, `a_cnt`.
- **LOAD_X**
  - `s_x_tready`=1.
  - Each `s_x` handshake writes `xbuf[wr_ptr]`, then `wr_ptr`++.
  - Handshake at `wr_ptr`=`INPUT_SIZE`-1 -> BIAS.
- **BIAS**
  - `s_b_tready`=1.
  - On handshake, latch `bias_reg` <= `s_b_tdata` -> RUN.
- **RUN**
  - `m_b_tdata`=`bias_reg`, `m_b_tvalid`=1. `bias_reg` stays stable for the whole tile.
  - `m_x_tdata` = `xbuf[rd_ptr]` (asynchronous read); `m_w_tdata` = `s_w_tdata`.
  - Joint valid: `m_x_tvalid` = `m_w_tvalid` = `s_w_tvalid` & (`beat_cnt` < `INPUT_SIZE`).
  - `s_w_tready` = `m_x_tready` & `m_w_tready` & (`beat_cnt` < `INPUT_SIZE`).
  - A beat transfers only when both `m_x` and `m_w` handshake in the same cycle; then `rd_ptr`++ and `beat_cnt`++.
  - After the beat at `beat_cnt`=`INPUT_SIZE`-1 -> DRAIN. Deassert all `m_x`/`m_w` valids from that edge.
- **DRAIN**
  - Pass-through: `m_a_tdata`=`c_a_tdata`, `m_a_tvalid`=`c_a_tvalid`, `c_a_tready`=`m_a_tready`, `m_a_tuser`=`tile_idx`.
  - `m_a_tlast`=1 when `a_cnt`=`OUT_PER_TILE`-1.
  - Each handshake increments `a_cnt`.
  - Last handshake with `tile_idx`=`N_TILES`-1 -> DONE.
  - Last handshake otherwise -> BIAS, with `tile_idx`++, and `rd_ptr`, `beat_cnt`, `a_cnt` cleared.
- **DONE**
  - `done`=1 for one cycle -> IDLE.
- Outside their owning state, every ready and valid is 0. `c_a_tready`=0 outside DRAIN, so stray cluster beats are back-pressured, never dropped silently.
- Pointer and counter widths: `clog2(INPUT_SIZE+1)` for `wr_ptr`, `rd_ptr`, `beat_cnt`; `clog2(OUT_PER_TILE+1)` for `a_cnt`. No wrap is needed, because each counter is cleared before reuse.

## Timing
- Reset (`RST`=0 at a clock edge), from any state, takes effect next edge:
  - state IDLE.
  - All tvalid/tready outputs 0, `busy`=0, `done`=0.
  - `m_a_tlast`=0, `tile_idx`=0, `bias_reg`=0. All counters 0.
  - Buffer contents are not cleared.
- `start` asserted while `busy`=1 is ignored.
- `start` and `RST`=0 in the same cycle: reset wins.
- LOAD_X with continuous `s_x_tvalid`: `INPUT_SIZE` cycles.
- BIAS: ≥1 cycle.
- RUN with no stalls: `INPUT_SIZE` cycles. `m_x_tvalid` is high on the first cycle after entering RUN.
- Any stall (`s_w_tvalid`=0, or either cluster ready low) holds `rd_ptr`, `beat_cnt` and the data outputs unchanged.
- Pointers advance only on the joint handshake; a lone `m_x_tready` or `m_w_tready` advances nothing.
- DONE to IDLE: 1 cycle. `busy` drops the same edge `done` drops.
- A `m_a` handshake in the same cycle as the DRAIN→BIAS transition is counted exactly once.

## Test plan
- **Single tile, no stall.** `INPUT_SIZE`=4, `N_TILES`=1, `OUT_PER_TILE`=3. Pixels 0x001..0x004, bias 0xA, weights W0..W3, cluster activations 7,8,9.
  - Cluster sees x 0x001..0x004 paired with W0..W3 on 4 consecutive cycles.
  - `m_a` outputs 7,8,9 with `tlast` on 9 and `tuser`=0.
  - `done` pulses once.
- **Multi-tile.** `N_TILES`=2.
  - Both tiles replay identical x 0x001..0x004, with `bias_reg` taking the first then the second bias beat.
  - `m_a_tuser` is 0 for the first 3 beats and 1 for the next 3.
  - Exactly 2 `tlast` pulses.
- **Back-pressure.** Drop `m_w_tready` for 2 cycles mid-RUN and `s_w_tvalid` for 1 cycle.
  - No pixel is skipped or duplicated; the x/w pairing is preserved.
  - RUN lasts 4+3 cycles.
- **Start ignored while busy.** Pulse `start` during RUN.
  - No state change; `done` occurs once.
- **Reset mid-DRAIN.** `RST`=0 after the second activation.
  - Next edge: IDLE; all valids/readys 0, `tile_idx`=0.
  - A fresh `start` runs a full correct image.
- **Stray activations.** Cluster asserts `c_a_tvalid` during RUN.
  - `c_a_tready` stays 0 and `m_a_tvalid` stays 0 until DRAIN.

Source files
------------

// File: rtl/cluster_sched.sv
`default_nettype none
// ============================================================================
// Module   : cluster_sched
// Purpose  : Tile scheduler that time-multiplexes one 48-output matmul cluster
//            over N_TILES output tiles of a fully-connected layer. Buffers one
//            image, then for each tile latches a bias beat, replays the image
//            in lock-step with that tile's weight stream, and forwards the
//            tile's activations downstream tagged with the tile index.
// Ports    : CLK, RST (sync, active-low), start / busy / done
//            s_x_*  : image pixel stream in (12-bit, 3 packed 4-bit pixels)
//            s_w_*  : weight stream in, INPUT_SIZE beats per tile
//            s_b_*  : bias stream in, one beat per tile
//            m_x_*  : pixels to cluster   m_w_* : weights to cluster
//            m_b_*  : held bias to cluster (no ready)
//            c_a_*  : activations from cluster
//            m_a_*  : activations downstream, tuser = tile index
//            tile_idx : current tile
// Revision : 1.0 - initial release
// ============================================================================
module cluster_sched #(
  parameter int INPUT_SIZE   = 784,
  parameter int N_TILES      = 4,
  parameter int OUT_PER_TILE = 48,
  localparam int TILE_W      = (N_TILES > 1) ? $clog2(N_TILES) : 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic [11:0]       s_x_tdata,
  input  logic              s_x_tvalid,
  output logic              s_x_tready,
  input  logic [63:0]       s_w_tdata,
  input  logic              s_w_tvalid,
  output logic              s_w_tready,
  input  logic [63:0]       s_b_tdata,
  input  logic              s_b_tvalid,
  output logic              s_b_tready,
  output logic [11:0]       m_x_tdata,
  output logic              m_x_tvalid,
  input  logic              m_x_tready,
  output logic [63:0]       m_w_tdata,
  output logic              m_w_tvalid,
  input  logic              m_w_tready,
  output logic [63:0]       m_b_tdata,
  output logic              m_b_tvalid,
  input  logic [63:0]       c_a_tdata,
  input  logic              c_a_tvalid,
  output logic              c_a_tready,
  output logic [63:0]       m_a_tdata,
  output logic              m_a_tvalid,
  input  logic              m_a_tready,
  output logic              m_a_tlast,
  output logic [TILE_W-1:0] m_a_tuser,
  output logic [TILE_W-1:0] tile_idx
);

  localparam int PTR_W  = $clog2(INPUT_SIZE + 1);
  localparam int ACNT_W = $clog2(OUT_PER_TILE + 1);
  localparam int ADDR_W = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;

  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W-1:0]  LAST_BEAT = PTR_W'(INPUT_SIZE - 1);
  localparam logic [PTR_W-1:0]  NUM_BEATS = PTR_W'(INPUT_SIZE);
  localparam logic [ACNT_W-1:0] ACNT_ONE  = ACNT_W'(1);
  localparam logic [ACNT_W-1:0] A_LAST    = ACNT_W'(OUT_PER_TILE - 1);
  localparam logic [TILE_W-1:0] TILE_ONE  = TILE_W'(1);
  localparam logic [TILE_W-1:0] TILE_LAST = TILE_W'(N_TILES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_X = 3'd1,
    BIAS   = 3'd2,
    RUN    = 3'd3,
    DRAIN  = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [11:0]       xbuf [0:INPUT_SIZE-1];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  beat_cnt;
  logic [ACNT_W-1:0] a_cnt;
  logic [63:0]       bias_reg;

  logic              beats_left;
  logic              x_hs;
  logic              b_hs;
  logic              w_hs;
  logic              a_hs;

  assign beats_left = (beat_cnt < NUM_BEATS);
  assign busy       = (state != IDLE);

  // Image replay reads the buffer combinationally so the pixel lines up with
  // the weight beat currently presented on s_w_tdata.
  assign m_x_tdata = xbuf[rd_ptr[ADDR_W-1:0]];
  assign m_w_tdata = s_w_tdata;
  assign m_b_tdata = bias_reg;
  assign m_a_tdata = c_a_tdata;
  assign m_a_tuser = tile_idx;

  // --------------------------------------------------------------------------
  // Next-state and handshake/output decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt  = state;
    s_x_tready = 1'b0;
    s_b_tready = 1'b0;
    s_w_tready = 1'b0;
    m_x_tvalid = 1'b0;
    m_w_tvalid = 1'b0;
    m_b_tvalid = 1'b0;
    c_a_tready = 1'b0;
    m_a_tvalid = 1'b0;
    m_a_tlast  = 1'b0;
    done       = 1'b0;
    x_hs       = 1'b0;
    b_hs       = 1'b0;
    w_hs       = 1'b0;
    a_hs       = 1'b0;

    case (state)
      IDLE: begin
        if (start) state_nxt = LOAD_X;
      end

      LOAD_X: begin
        s_x_tready = 1'b1;
        x_hs       = s_x_tvalid;
        if (x_hs && (wr_ptr == LAST_BEAT)) state_nxt = BIAS;
      end

      BIAS: begin
        s_b_tready = 1'b1;
        b_hs       = s_b_tvalid;
        if (b_hs) state_nxt = RUN;
      end

      RUN: begin
        // x and w are one joint transfer: both valids follow the weight
        // source and the weight source only sees ready when both cluster
        // ports are ready, so neither side can advance alone.
        m_b_tvalid = 1'b1;
        m_x_tvalid = s_w_tvalid & beats_left;
        m_w_tvalid = s_w_tvalid & beats_left;
        s_w_tready = m_x_tready & m_w_tready & beats_left;
        w_hs       = s_w_tvalid & m_x_tready & m_w_tready & beats_left;
        if (w_hs && (beat_cnt == LAST_BEAT)) state_nxt = DRAIN;
      end

      DRAIN: begin
        c_a_tready = m_a_tready;
        m_a_tvalid = c_a_tvalid;
        m_a_tlast  = (a_cnt == A_LAST);
        a_hs       = c_a_tvalid & m_a_tready;
        if (a_hs && (a_cnt == A_LAST)) begin
          state_nxt = (tile_idx == TILE_LAST) ? DONE : BIAS;
        end
      end

      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State, pointers, counters and bias holding register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      beat_cnt <= '0;
      a_cnt    <= '0;
      tile_idx <= '0;
      bias_reg <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            beat_cnt <= '0;
            a_cnt    <= '0;
            tile_idx <= '0;
          end
        end

        LOAD_X: begin
          if (x_hs) wr_ptr <= wr_ptr + PTR_ONE;
        end

        BIAS: begin
          if (b_hs) bias_reg <= s_b_tdata;
        end

        RUN: begin
          if (w_hs) begin
            rd_ptr   <= rd_ptr + PTR_ONE;
            beat_cnt <= beat_cnt + PTR_ONE;
          end
        end

        DRAIN: begin
          if (a_hs) begin
            // The closing beat of a non-final tile clears the counter rather
            // than incrementing it, so that beat is counted exactly once.
            if ((a_cnt == A_LAST) && (tile_idx != TILE_LAST)) begin
              tile_idx <= tile_idx + TILE_ONE;
              rd_ptr   <= '0;
              beat_cnt <= '0;
              a_cnt    <= '0;
            end else begin
              a_cnt <= a_cnt + ACNT_ONE;
            end
          end
        end

        default: ;
      endcase
    end
  end

  // Image buffer has no reset; its contents survive until overwritten.
  always_ff @(posedge CLK) begin
    if (RST && x_hs) xbuf[wr_ptr[ADDR_W-1:0]] <= s_x_tdata;
  end

endmodule
`default_nettype wire

// File: tb/tb_cluster_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_cluster_sched
// Purpose  : Self-checking bench for cluster_sched. Acts as pixel/weight/bias
//            sources, the matmul cluster and the downstream sink, and predicts
//            every control output from transaction counts of the stream model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cluster_sched;

  localparam int IS  = 4;
  localparam int NT  = 2;
  localparam int OPT = 3;
  localparam int TW  = (NT > 1) ? $clog2(NT) : 1;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          start = 1'b0;
  logic          busy, done;
  logic [11:0]   s_x_tdata = '0;
  logic          s_x_tvalid = 1'b0;
  logic          s_x_tready;
  logic [63:0]   s_w_tdata = '0;
  logic          s_w_tvalid = 1'b0;
  logic          s_w_tready;
  logic [63:0]   s_b_tdata = '0;
  logic          s_b_tvalid = 1'b0;
  logic          s_b_tready;
  logic [11:0]   m_x_tdata;
  logic          m_x_tvalid;
  logic          m_x_tready = 1'b0;
  logic [63:0]   m_w_tdata;
  logic          m_w_tvalid;
  logic          m_w_tready = 1'b0;
  logic [63:0]   m_b_tdata;
  logic          m_b_tvalid;
  logic [63:0]   c_a_tdata = '0;
  logic          c_a_tvalid = 1'b0;
  logic          c_a_tready;
  logic [63:0]   m_a_tdata;
  logic          m_a_tvalid;
  logic          m_a_tready = 1'b0;
  logic          m_a_tlast;
  logic [TW-1:0] m_a_tuser;
  logic [TW-1:0] tile_idx;

  int checks   = 0;
  int failures = 0;

  // Per-image stimulus and reference data
  logic [11:0] pix  [IS];
  logic [63:0] wts  [NT*IS];
  logic [63:0] bias [NT];
  logic [63:0] acts [NT*OPT];

  cluster_sched #(
    .INPUT_SIZE  (IS),
    .N_TILES     (NT),
    .OUT_PER_TILE(OPT)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .s_x_tdata (s_x_tdata),
    .s_x_tvalid(s_x_tvalid),
    .s_x_tready(s_x_tready),
    .s_w_tdata (s_w_tdata),
    .s_w_tvalid(s_w_tvalid),
    .s_w_tready(s_w_tready),
    .s_b_tdata (s_b_tdata),
    .s_b_tvalid(s_b_tvalid),
    .s_b_tready(s_b_tready),
    .m_x_tdata (m_x_tdata),
    .m_x_tvalid(m_x_tvalid),
    .m_x_tready(m_x_tready),
    .m_w_tdata (m_w_tdata),
    .m_w_tvalid(m_w_tvalid),
    .m_w_tready(m_w_tready),
    .m_b_tdata (m_b_tdata),
    .m_b_tvalid(m_b_tvalid),
    .c_a_tdata (c_a_tdata),
    .c_a_tvalid(c_a_tvalid),
    .c_a_tready(c_a_tready),
    .m_a_tdata (m_a_tdata),
    .m_a_tvalid(m_a_tvalid),
    .m_a_tready(m_a_tready),
    .m_a_tlast (m_a_tlast),
    .m_a_tuser (m_a_tuser),
    .tile_idx  (tile_idx)
  );

  always #5 CLK = ~CLK;

  function automatic bit pct(input int p);
    return ($urandom_range(0, 99) < p);
  endfunction

  function automatic logic [9:0] ctrl_now();
    return {s_x_tready, s_b_tready, s_w_tready, m_x_tvalid, m_w_tvalid,
            m_b_tvalid, c_a_tready, m_a_tvalid, busy, done};
  endfunction

  task automatic test_reset();
    RST = 1'b0;
    start = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    #1;
    checks++;
    if (ctrl_now() !== 10'b0 || tile_idx !== '0 || m_a_tlast !== 1'b0) begin
      failures++;
      $display("FAIL reset_state ctrl=%b tile=%0d tlast=%b exp ctrl=0 tile=0 tlast=0",
               ctrl_now(), tile_idx, m_a_tlast);
    end
    start = 1'b0;
    RST = 1'b1;
  endtask

  // One image transaction. Phase is derived purely from how many pixels,
  // biases, weights and activations have been exchanged so far.
  task automatic run_image(input string tag, input int px_pct, input int w_pct,
                           input int rdy_pct, input int ca_pct, input int ma_pct,
                           input bit start_noise, input int abort_at,
                           input bit directed, input bit check_cycles);
    int xi, bi, wi, ai, n;
    bit fin, aborted;
    bit load, bias_ph, run_ph, drain_ph, done_ph;
    logic [9:0] exp_ctrl;
    logic [TW-1:0] exp_tile;

    for (int i = 0; i < IS; i++)       pix[i]  = directed ? 12'(i + 1) : 12'($urandom);
    for (int t = 0; t < NT; t++)       bias[t] = directed ? 64'(10 + t) : {$urandom, $urandom};
    for (int i = 0; i < NT*IS; i++)    wts[i]  = {$urandom, $urandom};
    for (int i = 0; i < NT*OPT; i++)   acts[i] = directed ? 64'(7 + i) : {$urandom, $urandom};

    // Start cycle: junk valids must not leak through while idle.
    @(negedge CLK);
    start = 1'b1;
    s_x_tvalid = 1'b1; s_w_tvalid = 1'b1; s_b_tvalid = 1'b1; c_a_tvalid = 1'b1;
    m_x_tready = 1'b1; m_w_tready = 1'b1; m_a_tready = 1'b1;
    #1;
    checks++;
    if (ctrl_now() !== 10'b0) begin
      failures++;
      $display("FAIL %s idle_before_start ctrl=%b exp=%b", tag, ctrl_now(), 10'b0);
    end

    xi = 0; bi = 0; wi = 0; ai = 0; n = 0; fin = 0; aborted = 0;
    while (!fin) begin
      @(negedge CLK);
      n++;
      if (abort_at >= 0 && ai == abort_at) begin
        // Reset in DRAIN with start also high: reset must win.
        RST = 1'b0; start = 1'b1; c_a_tvalid = 1'b1; m_a_tready = 1'b1;
        @(negedge CLK);
        RST = 1'b1; start = 1'b0;
        #1;
        checks++;
        if (ctrl_now() !== 10'b0 || tile_idx !== '0 || m_a_tlast !== 1'b0) begin
          failures++;
          $display("FAIL %s reset_mid_drain ctrl=%b tile=%0d tlast=%b exp ctrl=0 tile=0 tlast=0",
                   tag, ctrl_now(), tile_idx, m_a_tlast);
        end
        fin = 1; aborted = 1;
      end else begin
        start      = start_noise ? pct(30) : 1'b0;
        s_x_tvalid = (xi < IS) && pct(px_pct);
        s_x_tdata  = 12'($urandom);
        if (xi < IS) s_x_tdata = pix[xi];
        s_b_tvalid = (bi < NT) && pct(px_pct);
        s_b_tdata  = {$urandom, $urandom};
        if (bi < NT) s_b_tdata = bias[bi];
        s_w_tvalid = (wi < NT*IS) && pct(w_pct);
        s_w_tdata  = {$urandom, $urandom};
        if (wi < NT*IS) s_w_tdata = wts[wi];
        m_x_tready = pct(rdy_pct);
        m_w_tready = pct(rdy_pct);
        c_a_tvalid = (ai < NT*OPT) && pct(ca_pct);
        c_a_tdata  = {$urandom, $urandom};
        if (ai < NT*OPT) c_a_tdata = acts[ai];
        m_a_tready = pct(ma_pct);
        #1;

        done_ph  = (ai == NT*OPT);
        load     = (xi < IS);
        run_ph   = !load && bi > 0 && wi < bi*IS;
        drain_ph = !load && bi > 0 && wi == bi*IS && ai < bi*OPT;
        bias_ph  = !load && !run_ph && !drain_ph && !done_ph;

        exp_ctrl = {load, bias_ph, run_ph && m_x_tready && m_w_tready,
                    run_ph && s_w_tvalid, run_ph && s_w_tvalid, run_ph,
                    drain_ph && m_a_tready, drain_ph && c_a_tvalid, 1'b1, done_ph};
        checks++;
        if (ctrl_now() !== exp_ctrl) begin
          failures++;
          $display("FAIL %s ctrl cyc=%0d got=%b exp=%b", tag, n, ctrl_now(), exp_ctrl);
        end

        if (load)         exp_tile = '0;
        else if (bias_ph) exp_tile = TW'(bi);
        else if (done_ph) exp_tile = TW'(NT - 1);
        else              exp_tile = TW'(bi - 1);
        checks++;
        if (tile_idx !== exp_tile) begin
          failures++;
          $display("FAIL %s tile_idx cyc=%0d got=%0d exp=%0d", tag, n, tile_idx, exp_tile);
        end

        if (run_ph && s_w_tvalid && m_x_tready && m_w_tready) begin
          checks++;
          if (m_x_tdata !== pix[wi % IS] || m_w_tdata !== wts[wi] || m_b_tdata !== bias[bi-1]) begin
            failures++;
            $display("FAIL %s xw_pair beat=%0d got x=%h w=%h b=%h exp x=%h w=%h b=%h",
                     tag, wi, m_x_tdata, m_w_tdata, m_b_tdata, pix[wi % IS], wts[wi], bias[bi-1]);
          end
        end

        if (drain_ph) begin
          checks++;
          if (m_a_tdata !== c_a_tdata || m_a_tuser !== TW'(ai / OPT) ||
              m_a_tlast !== ((ai % OPT) == OPT - 1)) begin
            failures++;
            $display("FAIL %s act beat=%0d got d=%h u=%0d l=%b exp d=%h u=%0d l=%b",
                     tag, ai, m_a_tdata, m_a_tuser, m_a_tlast, c_a_tdata, ai / OPT,
                     (ai % OPT) == OPT - 1);
          end
        end

        if (done_ph) begin
          fin = 1;
          if (check_cycles) begin
            checks++;
            if (n !== IS + NT*(1 + IS + OPT) + 1) begin
              failures++;
              $display("FAIL %s latency got=%0d exp=%0d", tag, n, IS + NT*(1 + IS + OPT) + 1);
            end
          end
        end

        // Advance the model on the handshakes it expects this cycle.
        if (load && s_x_tvalid) xi++;
        if (bias_ph && s_b_tvalid) bi++;
        if (run_ph && s_w_tvalid && m_x_tready && m_w_tready) wi++;
        if (drain_ph && c_a_tvalid && m_a_tready) ai++;

        if (n > 3000 && !fin) begin
          checks++; failures++;
          $display("FAIL %s timeout cyc=%0d x=%0d b=%0d w=%0d a=%0d", tag, n, xi, bi, wi, ai);
          fin = 1;
        end
      end
    end

    // Cycle after DONE (or after reset): back in IDLE with everything quiet.
    @(negedge CLK);
    start = 1'b0;
    s_x_tvalid = 1'b1; s_w_tvalid = 1'b1; s_b_tvalid = 1'b1; c_a_tvalid = 1'b1;
    #1;
    checks++;
    if (ctrl_now() !== 10'b0) begin
      failures++;
      $display("FAIL %s idle_after ctrl=%b exp=%b aborted=%0d", tag, ctrl_now(), 10'b0, aborted);
    end
  endtask

  task automatic test_single_image_no_stall();
    run_image("no_stall", 100, 100, 100, 100, 100, 0, -1, 1, 1);
  endtask

  task automatic test_back_pressure();
    for (int k = 0; k < 3; k++) run_image("back_pressure", 70, 60, 60, 60, 60, 0, -1, 0, 0);
  endtask

  task automatic test_start_while_busy();
    run_image("start_busy", 80, 80, 80, 80, 80, 1, -1, 0, 0);
  endtask

  task automatic test_stray_activations();
    run_image("stray_act", 90, 70, 70, 100, 70, 0, -1, 0, 0);
  endtask

  task automatic test_reset_mid_drain();
    run_image("reset_drain", 100, 100, 100, 100, 100, 0, 2, 1, 0);
    run_image("after_reset", 85, 85, 85, 85, 85, 0, -1, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_image("b2b_0", 100, 100, 100, 100, 100, 0, -1, 0, 1);
    run_image("b2b_1", 100, 100, 100, 100, 100, 0, -1, 0, 1);
  endtask

  initial begin
    test_reset();
    test_single_image_no_stall();
    test_back_pressure();
    test_start_while_busy();
    test_stray_activations();
    test_reset_mid_drain();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
